// File: rtl/ro_freq_meter.sv
// ro_freq_meter: ring-oscillator bank with windowed edge counter; define RO_FREQ_METER_CONTINUOUS_EN for free-running measurement
module ro_freq_meter_and (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

module ro_freq_meter_inv (
  input  logic a,
  output logic y
);
  assign y = ~a;
endmodule

module ro_freq_meter #(
  parameter int CHANNELS = 4,
  parameter int STAGES = 5,
  parameter int COUNT_W = 16,
  parameter int WIN_MAX_LOG2 = 15,
  parameter int PRESCALE_LOG2 = 2,
  localparam int SEL_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1,
  localparam int WL_W = $clog2(WIN_MAX_LOG2 + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] ring_en,
  input  logic [SEL_W-1:0]    sel,
  input  logic [WL_W-1:0]     win_log2,
  input  logic                test_mode,
  input  logic                test_clk_in,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [COUNT_W-1:0]  result,
  output logic                overflow,
  output logic [CHANNELS-1:0] ring_out
);
`ifdef RO_FREQ_METER_CONTINUOUS_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, SETTLE, COUNT, DONE} state_t;
  state_t state, state_nx;
  for (genvar k = 0; k < CHANNELS; k++) begin : g_ring
    logic [STAGES-1:0] n;
    (* keep = "true", dont_touch = "true" *)
    ro_freq_meter_and u_and (.a(ring_en[k]), .b(n[STAGES-1]), .y(n[0]));
    for (genvar s = 1; s < STAGES; s++) begin : g_inv
      (* keep = "true", dont_touch = "true" *)
      ro_freq_meter_inv u_inv (.a(n[s-1]), .y(n[s]));
    end
    assign ring_out[k] = n[0];
  end
  logic [SEL_W-1:0] sel_q;
  logic test_q;
  logic src;
  logic [PRESCALE_LOG2-1:0] pre;
  logic [2:0] sync;
  logic pulse;
  assign src = test_q ? test_clk_in : ring_out[sel_q];
  always_ff @(posedge src or negedge rst_n)
    if (!rst_n) pre <= '0;
    else pre <= pre + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= '0;
    else sync <= {sync[1:0], pre[PRESCALE_LOG2-1]};
  assign pulse = sync[1] & ~sync[2];
  logic [1:0] st_cnt;
  logic [WIN_MAX_LOG2-1:0] win_cnt, win_mask;
  logic [WL_W-1:0] win_q;
  logic [COUNT_W-1:0] acc;
  logic ovf, go, restart, win_end;
  assign go = start & (CONT | state == IDLE | state == DONE);
  assign restart = go | (CONT & state == DONE);
  assign win_mask = {WIN_MAX_LOG2{1'b1}} >> (WIN_MAX_LOG2 - int'(win_q));
  assign win_end = win_cnt == win_mask;
  assign busy = state == SETTLE || state == COUNT;
  always_comb begin
    state_nx = restart ? SETTLE
             : state == SETTLE && st_cnt == 2'd3 ? COUNT
             : state == COUNT && win_end ? DONE
             : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      st_cnt <= '0;
      win_cnt <= '0;
      acc <= '0;
      ovf <= 1'b0;
      sel_q <= '0;
      test_q <= 1'b0;
      win_q <= '0;
      result <= '0;
      overflow <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_nx;
      if (go) begin
        sel_q <= sel;
        test_q <= test_mode;
        win_q <= win_log2 > WL_W'(WIN_MAX_LOG2) ? WL_W'(WIN_MAX_LOG2) : win_log2;
      end
      st_cnt <= state == SETTLE && !restart ? st_cnt + 1'b1 : '0;
      win_cnt <= state == COUNT && !restart ? win_cnt + 1'b1 : '0;
      if (restart) begin
        acc <= '0;
        ovf <= 1'b0;
      end else if (state == COUNT && pulse) begin
        acc <= &acc ? acc : acc + 1'b1;
        ovf <= ovf | (&acc);
      end
      if (state == DONE) result <= acc;
      overflow <= go && !CONT ? 1'b0 : state == DONE ? ovf : overflow;
      done <= go ? 1'b0 : CONT ? state == DONE : done | state == DONE;
    end
endmodule

// File: tb/tb_ro_freq_meter.sv
// tb_ro_freq_meter: directed checks of the single-shot frequency meter using test_clk_in as source
module tb_ro_freq_meter;
  logic clk = 1'b0, rst_n = 1'b0, test_mode = 1'b0, test_clk_in = 1'b0, start = 1'b0;
  logic [3:0] ring_en = '0;
  logic [1:0] sel = '0;
  logic [3:0] win_log2 = '0;
  logic busy, done, overflow, s_busy, s_done, s_overflow;
  logic [15:0] result;
  logic [3:0] s_result, ring_out, s_ring_out;
  int total = 0, bad = 0, tdiv = 0, tcnt = 0, lat;

  ro_freq_meter u_dut (
    .clk(clk), .rst_n(rst_n), .ring_en(ring_en), .sel(sel), .win_log2(win_log2),
    .test_mode(test_mode), .test_clk_in(test_clk_in), .start(start), .busy(busy),
    .done(done), .result(result), .overflow(overflow), .ring_out(ring_out)
  );

  ro_freq_meter #(.COUNT_W(4), .PRESCALE_LOG2(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .ring_en(ring_en), .sel(sel), .win_log2(win_log2),
    .test_mode(test_mode), .test_clk_in(test_clk_in), .start(start), .busy(s_busy),
    .done(s_done), .result(s_result), .overflow(s_overflow), .ring_out(s_ring_out)
  );

  always #5 clk = ~clk;

  // test clock = clk/tdiv, toggled on the falling edge to stay clear of the sampling edge
  always @(negedge clk)
    if (tdiv > 0) begin
      if (tcnt >= tdiv / 2 - 1) begin
        tcnt = 0;
        test_clk_in = ~test_clk_in;
      end else tcnt++;
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic kick();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // n counts clk edges with the start-sampling edge as 1
  task automatic wait_done(inout int n);
    while (!done && n < 5000) begin
      @(posedge clk);
      #1 n++;
    end
    if (!done) chk("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_ring_out", {28'd0, ring_out}, 32'd0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    test_mode = 1'b1;
    tdiv = 8;
    win_log2 = 4'd10;
    repeat (4) @(posedge clk);
    kick();
    chk("cal_busy", {31'd0, busy}, 32'd1);
    chk("cal_done_low", {31'd0, done}, 32'd0);
    lat = 1;
    wait_done(lat);
    chk("cal_latency", lat, 32'd1030);
    chk("cal_result_32pm1", {31'd0, result >= 16'd31 && result <= 16'd33}, 32'd1);
    chk("cal_overflow", {31'd0, overflow}, 32'd0);
    chk("cal_busy_end", {31'd0, busy}, 32'd0);
    chk("cal_sat_result", {28'd0, s_result}, 32'd15);
    chk("cal_sat_overflow", {31'd0, s_overflow}, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("cal_hold_done", {31'd0, done}, 32'd1);
    chk("cal_hold_result", {31'd0, result >= 16'd31 && result <= 16'd33}, 32'd1);
    tdiv = 4;
    win_log2 = 4'd8;
    kick();
    chk("sat_done_drop", {31'd0, done}, 32'd0);
    chk("sat_overflow_clear", {31'd0, s_overflow}, 32'd0);
    lat = 1;
    wait_done(lat);
    chk("sat_latency", lat, 32'd262);
    chk("sat_result", {28'd0, s_result}, 32'd15);
    chk("sat_overflow", {31'd0, s_overflow}, 32'd1);
    chk("sat_main_result_16pm1", {31'd0, result >= 16'd15 && result <= 16'd17}, 32'd1);
    chk("sat_main_overflow", {31'd0, overflow}, 32'd0);
    tdiv = 8;
    win_log2 = 4'd6;
    kick();
    lat = 1;
    wait_done(lat);
    chk("single_latency", lat, 32'd70);
    chk("single_result_2pm1", {31'd0, result >= 16'd1 && result <= 16'd3}, 32'd1);
    kick();
    lat = 1;
    repeat (19) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("ign_busy", {31'd0, busy}, 32'd1);
    win_log2 = 4'd2;
    kick();
    lat++;
    wait_done(lat);
    chk("ign_latency", lat, 32'd70);
    chk("ign_result_2pm1", {31'd0, result >= 16'd1 && result <= 16'd3}, 32'd1);
    win_log2 = 4'd10;
    kick();
    repeat (9) @(posedge clk);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_result", {16'd0, result}, 32'd0);
    chk("mid_rst_overflow", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_idle_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_idle_done", {31'd0, done}, 32'd0);
    test_mode = 1'b0;
    sel = 2'd2;
    win_log2 = 4'd6;
    kick();
    chk("gate_ring_out_start", {28'd0, ring_out}, 32'd0);
    lat = 1;
    wait_done(lat);
    chk("gate_latency", lat, 32'd70);
    chk("gate_result", {16'd0, result}, 32'd0);
    chk("gate_overflow", {31'd0, overflow}, 32'd0);
    chk("gate_ring_out_end", {31'd0, ring_out[2]}, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
